up_sequencer: RTL

UP_SEQUENCER -- requirements
Module: up_sequencer

---
 rtl/up_sequencer_if.sv | 36 +++
 rtl/up_sequencer.sv | 124 ++++++++++++
 2 files changed

// File: rtl/up_sequencer_if.sv
// Control bundle between the micro-sequencer and the datapath it steers.
// The master side is the sequencer; the slave side is the datapath/RAM.
interface up_sequencer_if;
  logic       run;
  logic [3:0] instr;
  logic       c_flag;
  logic       z_flag;
  logic       ram_ready;

  logic       phase;
  logic       fetch_en;
  logic       inc_pc;
  logic       load_pc;
  logic       load_a;
  logic       load_flags;
  logic       load_out;
  logic [2:0] alu_sel;
  logic       cs_ram;
  logic       we_ram;
  logic       oe_alu;
  logic       oe_in;
  logic       oe_oprnd;
  logic       bus_err;

  modport master (
    input  run, instr, c_flag, z_flag, ram_ready,
    output phase, fetch_en, inc_pc, load_pc, load_a, load_flags, load_out,
           alu_sel, cs_ram, we_ram, oe_alu, oe_in, oe_oprnd, bus_err
  );

  modport slave (
    output run, instr, c_flag, z_flag, ram_ready,
    input  phase, fetch_en, inc_pc, load_pc, load_a, load_flags, load_out,
           alu_sel, cs_ram, we_ram, oe_alu, oe_in, oe_oprnd, bus_err
  );
endinterface

// File: rtl/up_sequencer.sv
// Two-phase fetch/execute micro-sequencer with a bounded RAM wait state.
// Strobes are decoded combinationally; only state, wait count and bus_err are stored.
module up_sequencer (
  input  logic           clock,
  input  logic           reset,
  up_sequencer_if.master bus
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] MWAIT = 2'd2;

  // Last MWAIT count before giving up: EXEC plus 15 MWAIT cycles is 16 in total.
  localparam logic [3:0] WCNT_LAST = 4'd14;

  logic [1:0] state, state_nxt;
  logic [3:0] wcnt, wcnt_nxt;
  logic       bus_err_q, bus_err_nxt;
  logic       is_mem;
  logic       done;
  logic       dec_load_a, dec_load_flags, dec_we_ram;

  always_comb begin
    unique case (bus.instr)
      4'b0011, 4'b0110, 4'b0111, 4'b1011, 4'b1111: is_mem = 1'b1;
      default:                                     is_mem = 1'b0;
    endcase
  end

  // A memory access completes only on ram_ready; everything else finishes in EXEC.
  assign done = !is_mem || bus.ram_ready;

  // NOTE: every output and next-state signal gets a default first, so no path
  // through the case statements leaves one unassigned and infers a latch.
  always_comb begin
    state_nxt      = state;
    wcnt_nxt       = wcnt;
    bus_err_nxt    = bus_err_q;
    bus.phase      = 1'b0;
    bus.fetch_en   = 1'b0;
    bus.inc_pc     = 1'b0;
    bus.load_pc    = 1'b0;
    bus.load_out   = 1'b0;
    bus.alu_sel    = 3'b000;
    bus.cs_ram     = 1'b0;
    bus.oe_alu     = 1'b0;
    bus.oe_in      = 1'b0;
    bus.oe_oprnd   = 1'b0;
    dec_load_a     = 1'b0;
    dec_load_flags = 1'b0;
    dec_we_ram     = 1'b0;

    if (!reset) begin
      unique case (state)
        FETCH: begin
          if (bus.run) begin
            bus.fetch_en = 1'b1;
            bus.inc_pc   = 1'b1;
            state_nxt    = EXEC;
          end
        end

        EXEC, MWAIT: begin
          bus.phase  = 1'b1;
          bus.cs_ram = is_mem;
          unique case (bus.instr)
            4'b0000: bus.load_pc = bus.c_flag;                       // JC
            4'b0001: bus.load_pc = !bus.c_flag;                      // JNC
            4'b1000: bus.load_pc = bus.z_flag;                       // JZ
            4'b1001: bus.load_pc = !bus.z_flag;                      // JNZ
            4'b1100: bus.load_pc = 1'b1;                             // JMP
            4'b0010: begin bus.oe_oprnd = 1'b1; bus.alu_sel = 3'b001; dec_load_flags = 1'b1; end
            4'b0100: begin bus.oe_oprnd = 1'b1; bus.alu_sel = 3'b010; dec_load_a = 1'b1; end
            4'b0101: begin bus.oe_in    = 1'b1; bus.alu_sel = 3'b010; dec_load_a = 1'b1; end
            4'b1010: begin bus.oe_oprnd = 1'b1; bus.alu_sel = 3'b011; dec_load_a = 1'b1; dec_load_flags = 1'b1; end
            4'b1110: begin bus.oe_oprnd = 1'b1; bus.alu_sel = 3'b100; dec_load_a = 1'b1; dec_load_flags = 1'b1; end
            4'b1101: begin bus.oe_alu   = 1'b1; bus.alu_sel = 3'b000; bus.load_out = 1'b1; end
            4'b0011: begin bus.alu_sel = 3'b001; dec_load_flags = 1'b1; end
            4'b0110: begin bus.alu_sel = 3'b010; dec_load_a = 1'b1; end
            4'b0111: begin bus.oe_alu  = 1'b1; bus.alu_sel = 3'b000; dec_we_ram = 1'b1; end
            4'b1011: begin bus.alu_sel = 3'b011; dec_load_a = 1'b1; dec_load_flags = 1'b1; end
            4'b1111: begin bus.alu_sel = 3'b100; dec_load_a = 1'b1; dec_load_flags = 1'b1; end
            default: ;
          endcase

          if (done) begin
            state_nxt = FETCH;
          end else if (state == EXEC) begin
            state_nxt = MWAIT;
            wcnt_nxt  = 4'd0;
          end else if (wcnt == WCNT_LAST) begin
            state_nxt   = FETCH;
            bus_err_nxt = 1'b1;
          end else begin
            wcnt_nxt = wcnt + 4'd1;
          end
        end

        default: state_nxt = FETCH;
      endcase
    end
  end

  // Data-side strobes of a memory opcode wait for the RAM handshake.
  assign bus.load_a     = dec_load_a     && done && !reset;
  assign bus.load_flags = dec_load_flags && done && !reset;
  assign bus.we_ram     = dec_we_ram     && done && !reset;
  assign bus.bus_err    = bus_err_q;

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // its next value from the same pre-edge snapshot.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= FETCH;
      wcnt      <= 4'd0;
      bus_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      wcnt      <= wcnt_nxt;
      bus_err_q <= bus_err_nxt;
    end
  end

endmodule
